// File: rtl/lab_pkg.sv
// Shared encodings for the lab datapath controller: sequencer modes and
// Counter mode-select codes, plus the bundled Counter/Moore control word.
package lab_pkg;

    localparam logic [1:0] MODE_STEP = 2'b00;
    localparam logic [1:0] MODE_AUTO = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;

    localparam logic [1:0] M_HOLD  = 2'b00;
    localparam logic [1:0] M_SHIFT = 2'b01;
    localparam logic [1:0] M_RUN   = 2'b10;

    typedef struct packed {
        logic       en_moore;
        logic       ce;
        logic       din;
        logic [1:0] m_sel;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c.en_moore = 1'b0;
        c.ce       = 1'b0;
        c.din      = 1'b0;
        c.m_sel    = M_HOLD;
        return c;
    endfunction

    function automatic ctrl_t ctrl_step();
        ctrl_t c;
        c.en_moore = 1'b1;
        c.ce       = 1'b1;
        c.din      = 1'b0;
        c.m_sel    = M_RUN;
        return c;
    endfunction

    function automatic ctrl_t ctrl_shift(input logic bit_i);
        ctrl_t c;
        c.en_moore = 1'b0;
        c.ce       = 1'b1;
        c.din      = bit_i;
        c.m_sel    = M_SHIFT;
        return c;
    endfunction

endpackage

// File: rtl/step_sequencer_tick_prescaler.sv
// DIV-cycle terminal-count generator: counts 0..DIV-1 while enabled and
// flags the wrap cycle; a synchronous clear restarts it from 0.
module tick_prescaler #(
    parameter int unsigned DIV = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    logic [PW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);
    assign tc_o    = en_i && !clr_i && at_last;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/step_sequencer.sv
// Lab datapath controller: turns one-shot button pulses into Moore enable
// pulses and Counter controls in STEP, AUTO and serial LOAD modes.
module step_sequencer #(
    parameter int unsigned N   = 4,
    parameter int unsigned DIV = 16
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         pb_step,
    input  logic         pb_mode,
    input  logic         pb_load,
    input  logic [N-1:0] load_val,
    output logic         en_moore,
    output logic         ce,
    output logic         din,
    output logic [1:0]   m_sel,
    output logic [1:0]   mode,
    output logic         busy
);

    import lab_pkg::*;

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

    logic [1:0]    mode_q, mode_d;
    logic [1:0]    saved_q, saved_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [IW-1:0] idx_q, idx_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          busy_q, busy_d;

    logic          auto_run;
    logic          tick;

    // Prescaler only advances while AUTO persists into the next cycle, so any
    // entry into AUTO (toggle or return from LOAD) starts it from 0.
    assign auto_run = (mode_q == MODE_AUTO) && !pb_load && !pb_mode;

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk_i  (CLK),
        .rst_ni (RSTn),
        .clr_i  (!auto_run),
        .en_i   (auto_run),
        .tc_o   (tick)
    );

    always_comb begin
        mode_d  = mode_q;
        saved_d = saved_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        ctrl_d  = ctrl_idle();

        case (mode_q)
            MODE_LOAD: begin
                if (idx_q == IDX_LAST) begin
                    mode_d = saved_q;
                    idx_d  = '0;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    ctrl_d  = ctrl_shift(shreg_q[N-1]);
                    shreg_d = shreg_q << 1;
                end
            end
            MODE_STEP, MODE_AUTO: begin
                if (pb_load) begin
                    saved_d = mode_q;
                    mode_d  = MODE_LOAD;
                    idx_d   = '0;
                    ctrl_d  = ctrl_shift(load_val[N-1]);
                    shreg_d = load_val << 1;
                end else if (pb_mode) begin
                    mode_d = (mode_q == MODE_STEP) ? MODE_AUTO : MODE_STEP;
                end else if ((mode_q == MODE_STEP) ? pb_step : tick) begin
                    ctrl_d = ctrl_step();
                end
            end
            default: begin
                mode_d = MODE_STEP;
            end
        endcase

        busy_d = (mode_d == MODE_LOAD);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            mode_q  <= MODE_STEP;
            saved_q <= MODE_STEP;
            shreg_q <= '0;
            idx_q   <= '0;
            ctrl_q  <= ctrl_idle();
            busy_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            saved_q <= saved_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            ctrl_q  <= ctrl_d;
            busy_q  <= busy_d;
        end
    end

    assign en_moore = ctrl_q.en_moore;
    assign ce       = ctrl_q.ce;
    assign din      = ctrl_q.din;
    assign m_sel    = ctrl_q.m_sel;
    assign mode     = mode_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios with literal
// expectations, then randomized pulses checked against a behavioural model.
module tb_step_sequencer;

    localparam int N   = 4;
    localparam int DIV = 16;

    // Output vector packing: {en_moore, ce, din, m_sel[1:0], mode[1:0], busy}
    localparam logic [7:0] IDLE_STEP  = 8'b0_0_0_00_00_0;
    localparam logic [7:0] STEP_PULSE = 8'b1_1_0_10_00_0;
    localparam logic [7:0] IDLE_AUTO  = 8'b0_0_0_00_01_0;
    localparam logic [7:0] AUTO_PULSE = 8'b1_1_0_10_01_0;
    localparam logic [7:0] SHIFT_1    = 8'b0_1_1_01_10_1;
    localparam logic [7:0] SHIFT_0    = 8'b0_1_0_01_10_1;

    logic         clk;
    logic         rst_n;
    logic         pb_step, pb_mode, pb_load;
    logic [N-1:0] load_val;
    logic         en_moore, ce, din, busy;
    logic [1:0]   m_sel, mode;
    logic [7:0]   dut_v;

    int n_cmp;
    int n_bad;
    int cyc;

    logic [7:0] mexp;
    logic [7:0] lit [int];

    step_sequencer #(
        .N   (N),
        .DIV (DIV)
    ) dut (
        .CLK      (clk),
        .RSTn     (rst_n),
        .pb_step  (pb_step),
        .pb_mode  (pb_mode),
        .pb_load  (pb_load),
        .load_val (load_val),
        .en_moore (en_moore),
        .ce       (ce),
        .din      (din),
        .m_sel    (m_sel),
        .mode     (mode),
        .busy     (busy)
    );

    assign dut_v = {en_moore, ce, din, m_sel, mode, busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode names as integers (0 STEP, 1 AUTO, 2 LOAD),
    // AUTO pacing as "cycles since entering AUTO is a multiple of DIV".
    initial begin : model
        int         mm, msaved, mage, mk;
        logic [N-1:0] mval;
        logic       e, c, d, b;
        logic [1:0] ms, md;
        cyc    = 0;
        mm     = 0;
        msaved = 0;
        mage   = 0;
        mk     = 0;
        mval   = '0;
        mexp   = IDLE_STEP;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                mm = 0; msaved = 0; mage = 0; mk = 0;
                mexp = IDLE_STEP;
            end else begin
                e = 0; c = 0; d = 0; ms = 2'b00;
                if (mm == 2) begin
                    if (mk == N - 1) begin
                        mm   = msaved;
                        mage = 0;
                    end else begin
                        mk++;
                        c = 1; ms = 2'b01; d = mval[N-1-mk];
                    end
                end else if (pb_load) begin
                    msaved = mm;
                    mval   = load_val;
                    mm     = 2;
                    mk     = 0;
                    c = 1; ms = 2'b01; d = mval[N-1];
                end else if (pb_mode) begin
                    mm   = (mm == 0) ? 1 : 0;
                    mage = 0;
                end else if (mm == 0) begin
                    if (pb_step) begin
                        e = 1; c = 1; ms = 2'b10;
                    end
                end else begin
                    mage++;
                    if (mage % DIV == 0) begin
                        e = 1; c = 1; ms = 2'b10;
                    end
                end
                md   = 2'(mm);
                b    = (mm == 2);
                mexp = {e, c, d, ms, md, b};
            end
        end
    end

    initial begin : compare
        logic [7:0] want;
        forever begin
            @(negedge clk);
            want = rst_n ? mexp : IDLE_STEP;
            n_cmp++;
            if (dut_v !== want) begin
                n_bad++;
                $display("FAIL model cyc=%0d rst_n=%0b got=%b want=%b (en ce din m_sel mode busy)",
                         cyc, rst_n, dut_v, want);
            end
            if (lit.exists(cyc)) begin
                n_cmp++;
                if (dut_v !== lit[cyc]) begin
                    n_bad++;
                    $display("FAIL literal cyc=%0d got=%b want=%b", cyc, dut_v, lit[cyc]);
                end
                lit.delete(cyc);
            end
        end
    end

    task automatic clear_inputs();
        pb_step = 1'b0;
        pb_mode = 1'b0;
        pb_load = 1'b0;
    endtask

    task automatic idle_to(input int c);
        clear_inputs();
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_cyc(input int c, input logic s, input logic m, input logic l,
                          input logic [N-1:0] v);
        idle_to(c);
        pb_step  = s;
        pb_mode  = m;
        pb_load  = l;
        load_val = v;
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic expect_at(input int c, input logic [7:0] v);
        lit[c] = v;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int b;
        int rst_hold;
        n_cmp    = 0;
        n_bad    = 0;
        rst_n    = 1'b0;
        load_val = '0;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single steps, including a back-to-back pair
        b = cyc + 2;
        expect_at(b + 11, STEP_PULSE);
        expect_at(b + 12, STEP_PULSE);
        expect_at(b + 13, IDLE_STEP);
        expect_at(b + 21, STEP_PULSE);
        expect_at(b + 22, IDLE_STEP);
        at_cyc(b + 10, 1, 0, 0, '0);
        at_cyc(b + 11, 1, 0, 0, '0);
        at_cyc(b + 20, 1, 0, 0, '0);
        idle_to(b + 25);

        // AUTO pacing and exit
        b = cyc + 2;
        expect_at(b + 6,  IDLE_AUTO);
        expect_at(b + 21, IDLE_AUTO);
        expect_at(b + 22, AUTO_PULSE);
        expect_at(b + 38, AUTO_PULSE);
        expect_at(b + 54, AUTO_PULSE);
        expect_at(b + 61, IDLE_STEP);
        expect_at(b + 70, IDLE_STEP);
        at_cyc(b + 5, 1, 1, 0, '0);
        at_cyc(b + 60, 0, 1, 0, '0);
        idle_to(b + 75);

        // Serial load from STEP, MSB first
        b = cyc + 2;
        expect_at(b + 9,  SHIFT_1);
        expect_at(b + 10, SHIFT_0);
        expect_at(b + 11, SHIFT_1);
        expect_at(b + 12, SHIFT_1);
        expect_at(b + 13, IDLE_STEP);
        at_cyc(b + 8, 0, 0, 1, 4'b1011);
        idle_to(b + 16);

        // All three pulses together in AUTO: load wins, return to AUTO
        b = cyc + 2;
        expect_at(b + 6,  SHIFT_0);
        expect_at(b + 7,  SHIFT_1);
        expect_at(b + 8,  SHIFT_1);
        expect_at(b + 9,  SHIFT_0);
        expect_at(b + 10, IDLE_AUTO);
        expect_at(b + 25, IDLE_AUTO);
        expect_at(b + 26, AUTO_PULSE);
        at_cyc(b, 0, 1, 0, '0);
        at_cyc(b + 5, 1, 1, 1, 4'b0110);
        at_cyc(b + 30, 0, 1, 0, '0);
        idle_to(b + 34);

        // Pulses during LOAD are dropped
        b = cyc + 2;
        expect_at(b + 4, SHIFT_1);
        expect_at(b + 6, SHIFT_1);
        expect_at(b + 7, IDLE_STEP);
        expect_at(b + 8, IDLE_STEP);
        at_cyc(b + 2, 0, 0, 1, 4'b1111);
        at_cyc(b + 3, 1, 0, 0, '0);
        at_cyc(b + 4, 0, 1, 0, '0);
        at_cyc(b + 5, 0, 0, 1, 4'b0000);
        idle_to(b + 10);

        // Reset on the second shift cycle abandons the load
        b = cyc + 2;
        expect_at(b + 3, SHIFT_1);
        expect_at(b + 4, IDLE_STEP);
        expect_at(b + 5, IDLE_STEP);
        expect_at(b + 6, IDLE_STEP);
        expect_at(b + 7, IDLE_STEP);
        at_cyc(b + 2, 0, 0, 1, 4'b1010);
        idle_to(b + 4);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle_to(b + 10);

        // Randomized pulses with occasional resets
        rst_hold = 0;
        for (int i = 0; i < 4000; i++) begin
            pb_step  = ($urandom_range(0, 3) == 0);
            pb_mode  = ($urandom_range(0, 19) == 0);
            pb_load  = ($urandom_range(0, 24) == 0);
            load_val = N'($urandom);
            if (rst_hold > 0) begin
                rst_hold--;
                rst_n = (rst_hold == 0);
            end else if ($urandom_range(0, 399) == 0) begin
                rst_n    = 1'b0;
                rst_hold = $urandom_range(1, 2);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        idle_to(cyc + 3);

        if (lit.num() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL literal_unvisited count=%0d want=0", lit.num());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
